// File: rtl/qbert_pkg.sv
// Shared types and pyramid geometry for the Q*bert jump sequencer.
package qbert_pkg;

  localparam int unsigned PYRAMID_ROWS = 7;
  localparam int unsigned DIR_W        = 3;
  localparam int unsigned POS_W        = 3;

  typedef enum logic [DIR_W-1:0] {
    DIR_NONE       = 3'b000,
    DIR_DOWN_RIGHT = 3'b001,
    DIR_DOWN_LEFT  = 3'b010,
    DIR_UP_RIGHT   = 3'b011,
    DIR_UP_LEFT    = 3'b100
  } qbert_dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_SETTLE,
    ST_OVER
  } move_state_t;

  typedef struct packed {
    logic             bad;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
  } qbert_target_t;

  function automatic logic dir_is_legal(logic [DIR_W-1:0] code);
    return (code >= 3'd1) && (code <= 3'd4);
  endfunction

  // Target cube of a jump; signed 4-bit math so moves above the apex go negative.
  function automatic qbert_target_t calc_target(logic [POS_W-1:0] row,
                                                logic [POS_W-1:0] col,
                                                logic [DIR_W-1:0] dir,
                                                int unsigned      rows);
    logic signed [3:0] r;
    logic signed [3:0] c;
    logic signed [3:0] r_lim;
    qbert_target_t     t;
    r     = signed'({1'b0, row});
    c     = signed'({1'b0, col});
    r_lim = signed'(4'(rows));
    case (dir)
      DIR_DOWN_RIGHT: begin r = r + 4'sd1; c = c + 4'sd1; end
      DIR_DOWN_LEFT:  r = r + 4'sd1;
      DIR_UP_RIGHT:   r = r - 4'sd1;
      DIR_UP_LEFT:    begin r = r - 4'sd1; c = c - 4'sd1; end
      default:        ;
    endcase
    t.bad = (c < 4'sd0) || (c > r) || (r >= r_lim);
    t.row = r[POS_W-1:0];
    t.col = c[POS_W-1:0];
    return t;
  endfunction

endpackage

// File: rtl/qbert_cmd_fifo.sv
// Small synchronous FIFO buffering jump directions; flush wins over push/pop.
module qbert_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_nxt_c = count;
    if (flush)
      count_nxt_c = '0;
    else if (do_push && !do_pop)
      count_nxt_c = count + CNT_W'(1);
    else if (do_pop && !do_push)
      count_nxt_c = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/qbert_move_ctrl.sv
// Jump sequencer: queues NIOS jump requests, issues them to the layer one at a
// time, tracks Q*bert's cube position, lives and game-over.
module qbert_move_ctrl
  import qbert_pkg::*;
#(
  parameter int unsigned ROWS          = PYRAMID_ROWS,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MOVE_TIMEOUT  = 32'd16777216,
  parameter int unsigned LIVES         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nios_start_qbert,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_dir,
  output logic       cmd_ready,
  input  logic       done_move,
  output logic       layer_start,
  output logic [2:0] qbert_jump,
  output logic       bad_jump,
  output logic [2:0] cube_row,
  output logic [2:0] cube_col,
  output logic       cube_visit,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       busy
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MOVE_W   = $clog2(MOVE_TIMEOUT + 1);

  move_state_t         state, state_nxt;
  logic [2:0]          qbert_jump_nxt;
  logic                bad_jump_nxt;
  logic [2:0]          tgt_row, tgt_row_nxt;
  logic [2:0]          tgt_col, tgt_col_nxt;
  logic [2:0]          cube_row_nxt, cube_col_nxt;
  logic                cube_visit_nxt;
  logic                layer_start_nxt;
  logic [1:0]          lives_nxt;
  logic                game_over_nxt;
  logic                busy_nxt;
  logic                cmd_ready_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
  logic [MOVE_W-1:0]   move_cnt, move_cnt_nxt;
  logic                lose_life;
  logic                move_expired;
  qbert_target_t       tgt;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic [2:0]          fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count_nxt;

  // Illegal direction codes are handshaken but silently dropped.
  assign fifo_push = cmd_valid && cmd_ready && !fifo_full && dir_is_legal(cmd_dir);

  qbert_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_cmd_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .flush       (fifo_flush),
    .din         (cmd_dir),
    .head_c      (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count_nxt_c (fifo_count_nxt)
  );

  assign move_expired = (move_cnt == MOVE_W'(MOVE_TIMEOUT - 1));

  // Next-state and next-output logic; a start request overrides everything.
  always_comb begin
    state_nxt       = state;
    qbert_jump_nxt  = qbert_jump;
    bad_jump_nxt    = bad_jump;
    tgt_row_nxt     = tgt_row;
    tgt_col_nxt     = tgt_col;
    cube_row_nxt    = cube_row;
    cube_col_nxt    = cube_col;
    cube_visit_nxt  = 1'b0;
    layer_start_nxt = 1'b0;
    lives_nxt       = lives;
    game_over_nxt   = game_over;
    settle_cnt_nxt  = settle_cnt;
    move_cnt_nxt    = move_cnt;
    fifo_pop        = 1'b0;
    fifo_flush      = 1'b0;
    lose_life       = 1'b0;
    tgt             = calc_target(cube_row, cube_col, fifo_head, ROWS);

    if (nios_start_qbert) begin
      fifo_flush      = 1'b1;
      cube_row_nxt    = '0;
      cube_col_nxt    = '0;
      lives_nxt       = 2'(LIVES);
      game_over_nxt   = 1'b0;
      qbert_jump_nxt  = DIR_NONE;
      bad_jump_nxt    = 1'b0;
      layer_start_nxt = 1'b1;
      settle_cnt_nxt  = '0;
      move_cnt_nxt    = '0;
      state_nxt       = ST_READY;
    end else begin
      case (state)
        ST_READY: begin
          if (!fifo_empty) begin
            fifo_pop       = 1'b1;
            qbert_jump_nxt = fifo_head;
            bad_jump_nxt   = tgt.bad;
            tgt_row_nxt    = tgt.row;
            tgt_col_nxt    = tgt.col;
            state_nxt      = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          move_cnt_nxt = '0;
          state_nxt    = ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!done_move) begin
            move_cnt_nxt = '0;
            state_nxt    = ST_WAIT_HIGH;
          end else if (move_expired) begin
            lose_life       = 1'b1;
            layer_start_nxt = 1'b1;
          end else begin
            move_cnt_nxt = move_cnt + MOVE_W'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (done_move) begin
            if (bad_jump) begin
              lose_life = 1'b1;
            end else begin
              qbert_jump_nxt = DIR_NONE;
              cube_row_nxt   = tgt_row;
              cube_col_nxt   = tgt_col;
              cube_visit_nxt = 1'b1;
              settle_cnt_nxt = '0;
              state_nxt      = ST_SETTLE;
            end
          end else if (move_expired) begin
            lose_life       = 1'b1;
            layer_start_nxt = 1'b1;
          end else begin
            move_cnt_nxt = move_cnt + MOVE_W'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            settle_cnt_nxt = '0;
            if (lives == '0) begin
              game_over_nxt = 1'b1;
              fifo_flush    = 1'b1;
              state_nxt     = ST_OVER;
            end else begin
              state_nxt = ST_READY;
            end
          end else begin
            settle_cnt_nxt = settle_cnt + SETTLE_W'(1);
          end
        end
        default: ;
      endcase

      // Bad landing and aborted move share the same penalty path.
      if (lose_life) begin
        qbert_jump_nxt = DIR_NONE;
        bad_jump_nxt   = 1'b0;
        cube_row_nxt   = '0;
        cube_col_nxt   = '0;
        if (lives != '0) lives_nxt = lives - 2'd1;
        settle_cnt_nxt = '0;
        state_nxt      = ST_SETTLE;
      end
    end

    busy_nxt      = (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT_LOW) ||
                    (state_nxt == ST_WAIT_HIGH) || (state_nxt == ST_SETTLE);
    cmd_ready_nxt = (fifo_count_nxt != CNT_W'(FIFO_DEPTH)) && (state_nxt != ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      qbert_jump  <= DIR_NONE;
      bad_jump    <= 1'b0;
      tgt_row     <= '0;
      tgt_col     <= '0;
      cube_row    <= '0;
      cube_col    <= '0;
      cube_visit  <= 1'b0;
      layer_start <= 1'b0;
      lives       <= 2'(LIVES);
      game_over   <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
      settle_cnt  <= '0;
      move_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      qbert_jump  <= qbert_jump_nxt;
      bad_jump    <= bad_jump_nxt;
      tgt_row     <= tgt_row_nxt;
      tgt_col     <= tgt_col_nxt;
      cube_row    <= cube_row_nxt;
      cube_col    <= cube_col_nxt;
      cube_visit  <= cube_visit_nxt;
      layer_start <= layer_start_nxt;
      lives       <= lives_nxt;
      game_over   <= game_over_nxt;
      busy        <= busy_nxt;
      cmd_ready   <= cmd_ready_nxt;
      settle_cnt  <= settle_cnt_nxt;
      move_cnt    <= move_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Bench for qbert_move_ctrl: layer handshake driven inline, checked against a
// position/lives/queue model built from the pyramid rules.
module tb_qbert_move_ctrl;

  localparam int ROWS    = 7;
  localparam int DEPTH   = 4;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 64;
  localparam int NLIVES  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       nios_start_qbert;
  logic       cmd_valid;
  logic [2:0] cmd_dir;
  logic       cmd_ready;
  logic       done_move;
  logic       layer_start;
  logic [2:0] qbert_jump;
  logic       bad_jump;
  logic [2:0] cube_row;
  logic [2:0] cube_col;
  logic       cube_visit;
  logic [1:0] lives;
  logic       game_over;
  logic       busy;

  always #5 clk = ~clk;

  qbert_move_ctrl #(
    .ROWS          (ROWS),
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .MOVE_TIMEOUT  (TIMEOUT),
    .LIVES         (NLIVES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .nios_start_qbert (nios_start_qbert),
    .cmd_valid        (cmd_valid),
    .cmd_dir          (cmd_dir),
    .cmd_ready        (cmd_ready),
    .done_move        (done_move),
    .layer_start      (layer_start),
    .qbert_jump       (qbert_jump),
    .bad_jump         (bad_jump),
    .cube_row         (cube_row),
    .cube_col         (cube_col),
    .cube_visit       (cube_visit),
    .lives            (lives),
    .game_over        (game_over),
    .busy             (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_row, m_col, m_lives;
  bit m_over;
  int m_q[$];
  int exp_dir, exp_bad, exp_row, exp_col;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic void model_target(input int dir, output int nr, output int nc,
                                       output int bad);
    nr = m_row;
    nc = m_col;
    case (dir)
      1: begin nr = nr + 1; nc = nc + 1; end
      2: nr = nr + 1;
      3: nr = nr - 1;
      4: begin nr = nr - 1; nc = nc - 1; end
      default: ;
    endcase
    bad = (nc >= 0 && nc <= nr && nr < ROWS) ? 0 : 1;
  endfunction

  function automatic void model_restart();
    m_row = 0; m_col = 0; m_lives = NLIVES; m_over = 0;
    m_q.delete();
  endfunction

  task automatic start_game();
    nios_start_qbert = 1'b1;
    tick();
    nios_start_qbert = 1'b0;
    model_restart();
    n_tests++;
    if ({layer_start, lives, game_over, cube_row, cube_col, cmd_ready} !==
        {1'b1, 2'(NLIVES), 1'b0, 3'd0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL start_state: ls=%0b lives=%0d go=%0b pos=(%0d,%0d) rdy=%0b expected ls=1 lives=%0d go=0 pos=(0,0) rdy=1",
               layer_start, lives, game_over, cube_row, cube_col, cmd_ready, NLIVES);
    end
    tick();
    n_tests++;
    if (layer_start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_pulse_width: layer_start=%0b expected 0", layer_start);
    end
  endtask

  task automatic push_cmd(input logic [2:0] d);
    logic exp_ready;
    exp_ready = !m_over && (m_q.size() < DEPTH);
    n_tests++;
    if (cmd_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL cmd_ready: got %0b expected %0b (queued=%0d)", cmd_ready, exp_ready, m_q.size());
    end
    cmd_valid = 1'b1;
    cmd_dir   = d;
    tick();
    cmd_valid = 1'b0;
    cmd_dir   = 3'd0;
    if (exp_ready && d >= 3'd1 && d <= 3'd4) m_q.push_back(int'(d));
  endtask

  task automatic await_issue();
    int waited;
    waited = 0;
    while (qbert_jump === 3'd0 && waited < 40) begin
      tick();
      waited++;
    end
    exp_dir = (m_q.size() > 0) ? m_q.pop_front() : 0;
    model_target(exp_dir, exp_row, exp_col, exp_bad);
    n_tests++;
    if (qbert_jump !== 3'(exp_dir)) begin
      n_fail++;
      $display("FAIL issue_dir: got %0d expected %0d after %0d cycles", qbert_jump, exp_dir, waited);
    end
    n_tests++;
    if (bad_jump !== 1'(exp_bad) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_bad: bad_jump=%0b busy=%0b expected bad_jump=%0b busy=1", bad_jump, busy, exp_bad);
    end
  endtask

  task automatic complete_move(input int drop_dly, input int high_dly);
    int visits;
    int waited;
    bit held;
    visits = 0;
    held   = 1;
    repeat (drop_dly) begin
      tick();
      if (qbert_jump !== 3'(exp_dir) || bad_jump !== 1'(exp_bad)) held = 0;
      if (cube_visit === 1'b1) visits++;
    end
    done_move = 1'b0;
    repeat (high_dly) begin
      tick();
      if (qbert_jump !== 3'(exp_dir) || bad_jump !== 1'(exp_bad)) held = 0;
      if (cube_visit === 1'b1) visits++;
    end
    done_move = 1'b1;
    tick();
    if (exp_bad == 0) begin
      m_row = exp_row; m_col = exp_col;
    end else begin
      m_row = 0; m_col = 0;
      if (m_lives > 0) m_lives--;
    end
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL jump_held: qbert_jump/bad_jump changed during move, expected %0d/%0d", exp_dir, exp_bad);
    end
    n_tests++;
    if ({qbert_jump, bad_jump} !== 4'd0 || cube_visit !== 1'(exp_bad == 0)) begin
      n_fail++;
      $display("FAIL land: jump=%0d bad=%0b visit=%0b expected jump=0 bad=0 visit=%0b",
               qbert_jump, bad_jump, cube_visit, (exp_bad == 0));
    end
    n_tests++;
    if (cube_row !== 3'(m_row) || cube_col !== 3'(m_col) || lives !== 2'(m_lives)) begin
      n_fail++;
      $display("FAIL land_pos: pos=(%0d,%0d) lives=%0d expected (%0d,%0d) lives=%0d",
               cube_row, cube_col, lives, m_row, m_col, m_lives);
    end
    if (cube_visit === 1'b1) visits++;
    waited = 0;
    while (busy === 1'b1 && waited < SETTLE + 8) begin
      tick();
      waited++;
      if (cube_visit === 1'b1) visits++;
    end
    n_tests++;
    if (waited != SETTLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL settle: busy low after %0d cycles (busy=%0b) expected %0d", waited, busy, SETTLE);
    end
    n_tests++;
    if (visits != ((exp_bad == 0) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL visit_count: got %0d expected %0d", visits, (exp_bad == 0) ? 1 : 0);
    end
    if (m_lives == 0) begin
      m_over = 1;
      n_tests++;
      if (game_over !== 1'b1 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL game_over: go=%0b rdy=%0b expected go=1 rdy=0", game_over, cmd_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; nios_start_qbert = 1'b0; cmd_valid = 1'b0; cmd_dir = 3'd0; done_move = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    model_restart();
    n_tests++;
    if ({qbert_jump, bad_jump, layer_start, cube_visit, cube_row, cube_col, lives, game_over, busy, cmd_ready} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'(NLIVES), 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: jump=%0d bad=%0b ls=%0b visit=%0b pos=(%0d,%0d) lives=%0d go=%0b busy=%0b rdy=%0b",
               qbert_jump, bad_jump, layer_start, cube_visit, cube_row, cube_col, lives, game_over, busy, cmd_ready);
    end
  endtask

  task automatic test_single_move();
    start_game();
    push_cmd(3'd1);
    n_tests++;
    if (qbert_jump !== 3'd0) begin
      n_fail++;
      $display("FAIL latency_early: qbert_jump=%0d one cycle after push, expected 0", qbert_jump);
    end
    tick();
    n_tests++;
    if (qbert_jump !== 3'd1) begin
      n_fail++;
      $display("FAIL latency: qbert_jump=%0d two cycles after push, expected 1", qbert_jump);
    end
    await_issue();
    complete_move(5, 40);
  endtask

  task automatic test_bad_jumps();
    start_game();
    for (int i = 0; i < NLIVES; i++) begin
      push_cmd(3'd3);
      await_issue();
      complete_move(2, 4);
    end
    push_cmd(3'd1);
    repeat (4) tick();
    n_tests++;
    if (qbert_jump !== 3'd0 || game_over !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL over_hold: jump=%0d go=%0b busy=%0b expected jump=0 go=1 busy=0", qbert_jump, game_over, busy);
    end
    start_game();
  endtask

  task automatic test_back_to_back();
    start_game();
    push_cmd(3'd1);
    await_issue();
    done_move = 1'b0;
    tick();
    push_cmd(3'd1);
    push_cmd(3'd2);
    push_cmd(3'd1);
    push_cmd(3'd2);
    push_cmd(3'd3);
    complete_move(0, 3);
    for (int i = 0; i < 4; i++) begin
      await_issue();
      complete_move(2, 5);
    end
  endtask

  task automatic test_timeout();
    int k;
    start_game();
    push_cmd(3'd1);
    await_issue();
    k = 0;
    while (layer_start !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    m_row = 0; m_col = 0; m_lives--;
    // One ISSUE cycle, then MOVE_TIMEOUT cycles waiting for done_move to fall
    n_tests++;
    if (k != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout_cycles: abort after %0d cycles expected %0d", k, TIMEOUT + 1);
    end
    n_tests++;
    if (cube_row !== 3'd0 || cube_col !== 3'd0 || lives !== 2'(m_lives) || qbert_jump !== 3'd0 || cube_visit !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: pos=(%0d,%0d) lives=%0d jump=%0d visit=%0b expected (0,0) lives=%0d jump=0 visit=0",
               cube_row, cube_col, lives, qbert_jump, cube_visit, m_lives);
    end
    k = 0;
    while (busy === 1'b1 && k < SETTLE + 8) begin
      tick();
      k++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_settle: busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_start_priority();
    bit quiet;
    start_game();
    push_cmd(3'd1);
    push_cmd(3'd2);
    await_issue();
    tick();
    done_move = 1'b0;
    repeat (3) tick();
    done_move = 1'b1;
    nios_start_qbert = 1'b1;
    tick();
    nios_start_qbert = 1'b0;
    model_restart();
    n_tests++;
    if ({cube_visit, cube_row, cube_col, layer_start, qbert_jump, lives, busy, cmd_ready} !==
        {1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 2'(NLIVES), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_wins: visit=%0b pos=(%0d,%0d) ls=%0b jump=%0d lives=%0d busy=%0b rdy=%0b",
               cube_visit, cube_row, cube_col, layer_start, qbert_jump, lives, busy, cmd_ready);
    end
    quiet = 1;
    repeat (10) begin
      tick();
      if (qbert_jump !== 3'd0 || cube_visit !== 1'b0) quiet = 0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL restart_flush: queued jump issued after restart, expected none");
    end
  endtask

  task automatic test_reset_mid_move();
    start_game();
    push_cmd(3'd2);
    await_issue();
    tick();
    done_move = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    done_move = 1'b1;
    tick();
    model_restart();
    n_tests++;
    if ({qbert_jump, bad_jump, busy, layer_start, cmd_ready, lives} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(NLIVES)}) begin
      n_fail++;
      $display("FAIL reset_mid_move: jump=%0d bad=%0b busy=%0b ls=%0b rdy=%0b lives=%0d",
               qbert_jump, bad_jump, busy, layer_start, cmd_ready, lives);
    end
  endtask

  task automatic test_random();
    logic [2:0] d;
    logic [2:0] ill;
    start_game();
    for (int i = 0; i < 24; i++) begin
      if (m_over) start_game();
      if ($urandom_range(0, 3) == 0) begin
        ill = 3'($urandom_range(5, 8));
        push_cmd(ill);
      end
      d = 3'($urandom_range(1, 4));
      push_cmd(d);
      await_issue();
      complete_move(int'($urandom_range(1, 6)), int'($urandom_range(2, 30)));
    end
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_bad_jumps();
    test_back_to_back();
    test_timeout();
    test_start_priority();
    test_reset_mid_move();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
